// File: rtl/aes_out_axis_serializer.sv
// AES result block FIFO feeding a 32-bit AXI-Stream master.
// Each 128-bit block leaves as four words, most significant word first.
module aes_out_axis_serializer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int BLK_FIFO_DEPTH       = 4,
    parameter int BYTE_SWAP            = 1,
    localparam int PW = $clog2(BLK_FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_aresetn,
    input  logic                                blk_valid,
    input  logic [127:0]                        blk_data,
    input  logic                                blk_last,
    output logic                                blk_ready,
    output logic                                m00_axis_tvalid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                m00_axis_tready,
    output logic [CW-1:0]                       blk_fifo_count,
    output logic                                pkt_done
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t         state_q, state_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic [127:0]   blk_q, blk_d;
    logic           last_q, last_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [128:0]   mem_q [BLK_FIFO_DEPTH];

    logic           push;
    logic           pop;
    logic           beat;
    logic           fifo_empty;
    logic [31:0]    word;

    // Ready is pure registered occupancy, forced low while reset is held
    assign blk_ready  = m00_axis_aresetn && (cnt_q < CW'(BLK_FIFO_DEPTH));
    assign push       = blk_valid && blk_ready;
    assign fifo_empty = (cnt_q == '0);
    assign beat       = m00_axis_tvalid && m00_axis_tready;

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q <= S_IDLE;
            wcnt_q  <= 2'd0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (push) begin
            mem_q[wptr_q] <= {blk_last, blk_data};
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SEND;
                    pop     = 1'b1;
                end
            end
            S_SEND: begin
                // Reload on the final beat so consecutive blocks have no bubble
                if (beat && (wcnt_q == 2'd3)) begin
                    if (fifo_empty) begin
                        state_d = S_IDLE;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        blk_d  = blk_q;
        last_d = last_q;
        wcnt_d = wcnt_q;
        if (pop) begin
            blk_d  = mem_q[rptr_q][127:0];
            last_d = mem_q[rptr_q][128];
            wcnt_d = 2'd0;
        end else if (beat) begin
            blk_d  = {blk_q[95:0], 32'h0};
            wcnt_d = wcnt_q + 2'd1;
        end
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        done_d = beat && m00_axis_tlast;
    end

    always_comb begin
        m00_axis_tvalid = (state_q == S_SEND);
        m00_axis_tlast  = (state_q == S_SEND) && (wcnt_q == 2'd3) && last_q;
    end

    // The shift register keeps the current word in its top 32 bits
    generate
        if (BYTE_SWAP != 0) begin : g_swap
            assign word = {blk_q[103:96], blk_q[111:104],
                           blk_q[119:112], blk_q[127:120]};
        end else begin : g_pass
            assign word = blk_q[127:96];
        end
    endgenerate

    assign m00_axis_tdata = word;
    assign m00_axis_tstrb = '1;
    assign blk_fifo_count = cnt_q;
    assign pkt_done       = done_q;

endmodule

// File: doc/aes_out_axis_serializer.md
AES_OUT_AXIS_SERIALIZER -- requirements
Module: aes_out_axis_serializer

Interface
REQ-001 Parameter C_M_AXIS_TDATA_WIDTH, default 32: master stream word width; only 32 is supported.
REQ-002 Parameter BLK_FIFO_DEPTH, default 4: block FIFO depth in 128-bit blocks; power of 2, at least 2.
REQ-003 Parameter BYTE_SWAP, default 1: 1 = reverse the byte order within each output word (kernel byte order); 0 = pass the word unchanged.
REQ-004 m00_axis_aclk  in  1  sole clock; all logic on the rising edge.
REQ-005 m00_axis_aresetn  in  1  asynchronous, active-low reset.
REQ-006 blk_valid  in  1  an upstream AES result block is offered.
REQ-007 blk_data  in  128  AES result block; bits [127:96] are word 0.
REQ-008 blk_last  in  1  the offered block is the final block of the packet.
REQ-009 blk_ready  out  1  the block FIFO can accept a block.
REQ-010 m00_axis_tvalid  out  1  AXI-Stream valid.
REQ-011 m00_axis_tdata  out  32  AXI-Stream data.
REQ-012 m00_axis_tstrb  out  4  constant 4'hF.
REQ-013 m00_axis_tlast  out  1  high on the final word of the final block.
REQ-014 m00_axis_tready  in  1  AXI-Stream ready.
REQ-015 blk_fifo_count  out  clog2(BLK_FIFO_DEPTH)+1  number of blocks held in the FIFO (excludes the block being sent).
REQ-016 pkt_done  out  1  one-cycle pulse marking the end of a packet.

Function
REQ-017 Block push occurs on a clock edge where blk_valid && blk_ready; the FIFO stores {blk_last, blk_data}.
REQ-018 blk_ready SHALL equal (blk_fifo_count < BLK_FIFO_DEPTH), registered-state only; there is no same-cycle pass-through when the FIFO is full, even if a pop occurs in that cycle.
REQ-019 blk_fifo_count: +1 on push only; -1 on pop only; unchanged on a simultaneous push and pop; wrap-around of read/write pointers is modulo BLK_FIFO_DEPTH.
REQ-020 FSM states: IDLE (no block loaded, tvalid=0) and SEND (block loaded, tvalid=1); 2-bit word counter wcnt.
REQ-021 IDLE -> SEND on the edge where the FIFO is non-empty; that edge pops the head entry into a 128-bit shift register and the last-flag register, and clears wcnt to 0.
REQ-022 Latency: a push into an empty FIFO while in IDLE at edge N gives tvalid=1 after edge N+1, with word 0 on tdata.
REQ-023 m00_axis_tdata = word wcnt of the loaded block (wcnt 0 = bits [127:96] ... wcnt 3 = bits [31:0]), byte-reversed when BYTE_SWAP=1.
REQ-024 When tvalid && !tready, tdata, tlast and tvalid SHALL hold stable.
REQ-025 A beat completes on tvalid && tready; wcnt increments, wrapping 3 -> 0.
REQ-026 m00_axis_tlast = (state==SEND) && (wcnt==3) && loaded last flag.
REQ-027 Beat at wcnt==3: if the FIFO is non-empty, pop the next block in the same edge and stay in SEND (no bubble); otherwise go to IDLE.
REQ-028 pkt_done SHALL pulse high for exactly one cycle, one cycle after a beat with tlast=1.
REQ-029 A block with blk_last=0 followed by an empty FIFO SHALL leave tvalid low until the next block arrives; a packet is never terminated without tlast.

Reset
REQ-030 Asserting m00_axis_aresetn low SHALL immediately, without waiting for a clock edge, force: state IDLE; tvalid=0; tlast=0; pkt_done=0; tdata=0; wcnt=0; pointers=0; blk_fifo_count=0; blk_ready=0 while reset is held.
REQ-031 Reset asserted mid-packet SHALL discard the loaded and queued blocks; there is no partial completion.
REQ-032 After release, blk_ready SHALL be 1 on the first edge; FIFO contents need no reset.

Verification
REQ-033 Single block 0x00112233_44556677_8899AABB_CCDDEEFF with last=1, tready=1, BYTE_SWAP=1 -> words 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC; tlast on word 4 only; pkt_done one cycle later.
REQ-034 Same stimulus with BYTE_SWAP=0 and tready toggling 1/0 each cycle -> words 0x00112233 ... 0xCCDDEEFF in order; tdata held during every stall; 8 cycles from the first tvalid to the last beat.
REQ-035 Push 4 blocks back-to-back with tready=0 -> blk_fifo_count reaches 3 with 1 block loaded, then 4 after the 5th push; blk_ready=0 at count 4; 6th offer is not accepted; raising tready -> 20 contiguous beats with no bubble and tlast only on the last block.
REQ-036 Simultaneous push and pop at count 2 -> count stays 2; data order is preserved across pointer wrap (more than 8 blocks streamed).
REQ-037 aresetn driven low between two clock edges during word 2 -> tvalid falls without a clock edge; after release, a new 1-block packet streams correctly with pkt_done=1 once.
